// File: rtl/mem_write_arbiter.sv
// Round-robin write-port arbiter for a simple dual-port memory, with a built-in
// clear engine that sweeps every address to CLEAR_VALUE after reset or on request.
module mem_write_arbiter #(
  parameter int                    NUM_REQ     = 2,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DEPTH       = 256,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int                    AW          = $clog2(DEPTH)  // derived; leave at default
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [AW-1:0]         req_addr [NUM_REQ],
  input  logic [DATA_WIDTH-1:0] req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  wea,
  output logic [AW-1:0]         addra,
  output logic [DATA_WIDTH-1:0] dia
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1) begin : g_bad_num_req
    $fatal(1, "mem_write_arbiter: NUM_REQ must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "mem_write_arbiter: DEPTH must be >= 2");
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  wea_q, wea_d;
  logic [AW-1:0]         addra_q, addra_d;
  logic [DATA_WIDTH-1:0] dia_q, dia_d;

  logic                  hi_hit, lo_hit;
  logic [PW-1:0]         hi_idx, lo_idx;
  logic [PW-1:0]         grant_idx;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(rr_ptr_q))) begin
        hi_hit = 1'b1;
        hi_idx = PW'(i);
      end
      if (req_valid[i]) begin
        lo_hit = 1'b1;
        lo_idx = PW'(i);
      end
    end
    grant_idx = hi_hit ? hi_idx : lo_idx;
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    wea_d     = 1'b0;
    addra_d   = addra_q;
    dia_d     = dia_q;
    req_ready = '0;

    case (state_q)
      ST_CLEAR: begin
        wea_d   = 1'b1;
        addra_d = cnt_q;
        dia_d   = CLEAR_VALUE;
        if (cnt_q == AW'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (lo_hit) begin
          req_ready[grant_idx] = 1'b1;
          wea_d    = 1'b1;
          addra_d  = req_addr[grant_idx];
          dia_d    = req_data[grant_idx];
          rr_ptr_d = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      wea_q    <= 1'b0;
      addra_q  <= '0;
      dia_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      wea_q    <= wea_d;
      addra_q  <= addra_d;
      dia_q    <= dia_d;
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign wea        = wea_q;
  assign addra      = addra_q;
  assign dia        = dia_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter: reset clear, round-robin fairness, single
// requester, clear_start contention, reset mid-clear and a non-power-of-two depth.
module tb_mem_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req_valid;
  logic [2:0] req_addr [3];
  logic [7:0] req_data [3];
  logic [2:0] req_ready;
  logic       clear_start;
  logic       clear_busy;
  logic       wea;
  logic [2:0] addra;
  logic [7:0] dia;

  logic       reset5;
  logic [1:0] req_valid5;
  logic [2:0] req_addr5 [2];
  logic [7:0] req_data5 [2];
  logic [1:0] req_ready5;
  logic       clear_start5;
  logic       clear_busy5;
  logic       wea5;
  logic [2:0] addra5;
  logic [7:0] dia5;

  logic [7:0] mem [8];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_write_arbiter #(
    .NUM_REQ(3), .DATA_WIDTH(8), .DEPTH(8), .CLEAR_VALUE(8'h5A)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clear_start(clear_start),
    .clear_busy(clear_busy), .wea(wea), .addra(addra), .dia(dia)
  );

  mem_write_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(8), .DEPTH(5), .CLEAR_VALUE(8'h3C)
  ) dut5 (
    .clk(clk), .reset(reset5), .req_valid(req_valid5), .req_addr(req_addr5),
    .req_data(req_data5), .req_ready(req_ready5), .clear_start(clear_start5),
    .clear_busy(clear_busy5), .wea(wea5), .addra(addra5), .dia(dia5)
  );

  // Memory model: commits on the edge after wea/addra/dia are presented.
  always @(posedge clk) if (wea) mem[addra] <= dia;

  task automatic test_reset();
    #12;
    checks++; if (wea !== 1'b0) $display("FAIL rst_wea got %b exp 0", wea); else passes++;
    checks++; if (addra !== 3'd0) $display("FAIL rst_addra got %0d exp 0", addra); else passes++;
    checks++; if (dia !== 8'h00) $display("FAIL rst_dia got %h exp 00", dia); else passes++;
    checks++; if (req_ready !== 3'b000) $display("FAIL rst_ready got %b exp 000", req_ready); else passes++;
    checks++; if (clear_busy !== 1'b1) $display("FAIL rst_busy got %b exp 1", clear_busy); else passes++;
  endtask

  task automatic test_reset_clear();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++; if (wea !== 1'b1) $display("FAIL clr_wea k=%0d got %b exp 1", k, wea); else passes++;
      checks++; if (addra !== 3'(k)) $display("FAIL clr_addra k=%0d got %0d exp %0d", k, addra, k); else passes++;
      checks++; if (dia !== 8'h5A) $display("FAIL clr_dia k=%0d got %h exp 5a", k, dia); else passes++;
      checks++;
      if (clear_busy !== (k < 7)) $display("FAIL clr_busy k=%0d got %b exp %b", k, clear_busy, (k < 7));
      else passes++;
    end
    @(posedge clk); #1;
    checks++; if (wea !== 1'b0) $display("FAIL clr_end_wea got %b exp 0", wea); else passes++;
    checks++; if (clear_busy !== 1'b0) $display("FAIL clr_end_busy got %b exp 0", clear_busy); else passes++;
    checks++; if (addra !== 3'd7) $display("FAIL clr_end_addra_hold got %0d exp 7", addra); else passes++;
    for (int a = 0; a < 8; a++) begin
      checks++; if (mem[a] !== 8'h5A) $display("FAIL clr_mem a=%0d got %h exp 5a", a, mem[a]); else passes++;
    end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_addr [3];
    logic [7:0] exp_data [3];
    exp_addr = '{3'd1, 3'd2, 3'd3};
    exp_data = '{8'hA0, 8'hA1, 8'hA2};
    req_valid = 3'b111;
    for (int j = 0; j < 6; j++) begin
      #1;
      checks++;
      if (req_ready !== 3'(1 << (j % 3))) $display("FAIL fair_ready j=%0d got %b exp %b", j, req_ready, 3'(1 << (j % 3)));
      else passes++;
      @(posedge clk); #1;
      checks++; if (wea !== 1'b1) $display("FAIL fair_wea j=%0d got %b exp 1", j, wea); else passes++;
      checks++;
      if (addra !== exp_addr[j % 3]) $display("FAIL fair_addra j=%0d got %0d exp %0d", j, addra, exp_addr[j % 3]);
      else passes++;
      checks++;
      if (dia !== exp_data[j % 3]) $display("FAIL fair_dia j=%0d got %h exp %h", j, dia, exp_data[j % 3]);
      else passes++;
    end
    req_valid = 3'b000;
    @(posedge clk); #1;
    checks++; if (wea !== 1'b0) $display("FAIL fair_idle_wea got %b exp 0", wea); else passes++;
    checks++; if (addra !== 3'd3) $display("FAIL fair_idle_addra_hold got %0d exp 3", addra); else passes++;
    checks++; if (dia !== 8'hA2) $display("FAIL fair_idle_dia_hold got %h exp a2", dia); else passes++;
  endtask

  task automatic test_single();
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) $display("FAIL single_pre_ready got %b exp 001", req_ready); else passes++;
    @(posedge clk); #1;
    req_valid   = 3'b100;
    req_addr[2] = 3'd5;
    req_data[2] = 8'hC3;
    #1;
    checks++; if (req_ready !== 3'b100) $display("FAIL single_ready got %b exp 100", req_ready); else passes++;
    @(posedge clk); #1;
    checks++; if (wea !== 1'b1) $display("FAIL single_wea got %b exp 1", wea); else passes++;
    checks++; if (addra !== 3'd5) $display("FAIL single_addra got %0d exp 5", addra); else passes++;
    checks++; if (dia !== 8'hC3) $display("FAIL single_dia got %h exp c3", dia); else passes++;
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b001) $display("FAIL single_ptr_wrap got %b exp 001", req_ready); else passes++;
    req_valid = 3'b000;
    @(posedge clk); #1;
    checks++; if (wea !== 1'b0) $display("FAIL single_idle_wea got %b exp 0", wea); else passes++;
  endtask

  task automatic test_clear_start();
    req_valid   = 3'b001;
    clear_start = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b000) $display("FAIL cs_pulse_ready got %b exp 000", req_ready); else passes++;
    @(posedge clk); #1;
    clear_start = 1'b0;
    checks++; if (wea !== 1'b0) $display("FAIL cs_idle_wea got %b exp 0", wea); else passes++;
    checks++; if (clear_busy !== 1'b1) $display("FAIL cs_busy_rise got %b exp 1", clear_busy); else passes++;
    checks++; if (req_ready !== 3'b000) $display("FAIL cs_ready0 got %b exp 000", req_ready); else passes++;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++; if (wea !== 1'b1) $display("FAIL cs_wea k=%0d got %b exp 1", k, wea); else passes++;
      checks++; if (addra !== 3'(k)) $display("FAIL cs_addra k=%0d got %0d exp %0d", k, addra, k); else passes++;
      checks++;
      if (req_ready !== ((k < 7) ? 3'b000 : 3'b001))
        $display("FAIL cs_ready k=%0d got %b exp %b", k, req_ready, (k < 7) ? 3'b000 : 3'b001);
      else passes++;
    end
    @(posedge clk); #1;
    checks++; if (wea !== 1'b1) $display("FAIL cs_grant_wea got %b exp 1", wea); else passes++;
    checks++; if (addra !== 3'd1) $display("FAIL cs_grant_addra got %0d exp 1", addra); else passes++;
    checks++; if (dia !== 8'hA0) $display("FAIL cs_grant_dia got %h exp a0", dia); else passes++;
    req_valid = 3'b000;
    @(posedge clk); #1;
    checks++; if (wea !== 1'b0) $display("FAIL cs_end_wea got %b exp 0", wea); else passes++;
  endtask

  task automatic test_reset_mid_clear();
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (addra !== 3'd3) $display("FAIL rmc_at3_addra got %0d exp 3", addra); else passes++;
    req_valid = 3'b111;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (wea !== 1'b0) $display("FAIL rmc_wea got %b exp 0", wea); else passes++;
    checks++; if (addra !== 3'd0) $display("FAIL rmc_addra got %0d exp 0", addra); else passes++;
    checks++; if (dia !== 8'h00) $display("FAIL rmc_dia got %h exp 00", dia); else passes++;
    checks++; if (req_ready !== 3'b000) $display("FAIL rmc_ready got %b exp 000", req_ready); else passes++;
    req_valid = 3'b000;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++; if (wea !== 1'b1) $display("FAIL rmc_re_wea k=%0d got %b exp 1", k, wea); else passes++;
      checks++; if (addra !== 3'(k)) $display("FAIL rmc_re_addra k=%0d got %0d exp %0d", k, addra, k); else passes++;
    end
    @(posedge clk); #1;
    checks++; if (wea !== 1'b0) $display("FAIL rmc_end_wea got %b exp 0", wea); else passes++;
    checks++; if (clear_busy !== 1'b0) $display("FAIL rmc_end_busy got %b exp 0", clear_busy); else passes++;
  endtask

  task automatic test_nonpow2();
    @(negedge clk);
    reset5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (wea5 !== 1'b1) $display("FAIL np2_wea k=%0d got %b exp 1", k, wea5); else passes++;
      checks++; if (addra5 !== 3'(k)) $display("FAIL np2_addra k=%0d got %0d exp %0d", k, addra5, k); else passes++;
      checks++; if (dia5 !== 8'h3C) $display("FAIL np2_dia k=%0d got %h exp 3c", k, dia5); else passes++;
      checks++;
      if (clear_busy5 !== (k < 4)) $display("FAIL np2_busy k=%0d got %b exp %b", k, clear_busy5, (k < 4));
      else passes++;
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (wea5 !== 1'b0) $display("FAIL np2_idle_wea k=%0d got %b exp 0", k, wea5); else passes++;
      checks++; if (addra5 !== 3'd4) $display("FAIL np2_idle_addra k=%0d got %0d exp 4", k, addra5); else passes++;
    end
  endtask

  initial begin
    reset        = 1'b1;
    reset5       = 1'b1;
    clear_start  = 1'b0;
    clear_start5 = 1'b0;
    req_valid    = 3'b000;
    req_valid5   = 2'b00;
    req_addr     = '{3'd1, 3'd2, 3'd3};
    req_data     = '{8'hA0, 8'hA1, 8'hA2};
    req_addr5    = '{3'd0, 3'd0};
    req_data5    = '{8'h00, 8'h00};

    test_reset();
    test_reset_clear();
    test_fairness();
    test_single();
    req_addr[2] = 3'd3;
    req_data[2] = 8'hA2;
    test_clear_start();
    test_reset_mid_clear();
    test_nonpow2();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_write_arbiter.md
# mem_write_arbiter

Shares the single write port (port A) of one `mem_simple_dual_port` instance among `NUM_REQ` requesters, e.g. host register writes and the operator pipeline's state write-back. It grants one requester per cycle, round-robin, through a valid/ready handshake. It also owns a clear engine that sweeps every address to `CLEAR_VALUE`, both after reset and on request. Its write-port outputs are registered and connect directly to the memory's `wea`/`addra`/`dia`.

## Interface
- `NUM_REQ`, default 2: number of requesters; must be ≥ 1.
- `DATA_WIDTH`, default 8: write data width.
- `DEPTH`, default 256: memory depth; must be ≥ 2; need not be a power of two.
- `CLEAR_VALUE`, default 0: value written by the clear engine.
- `AW`, derived as `$clog2(DEPTH)`: address width.

Illegal `NUM_REQ` or `DEPTH` values trigger `$fatal` at elaboration.

- `clk`  in  1  sole clock; also drives the memory's `clka`.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_addr`  in  NUM_REQ×AW  per-requester address (unpacked array).
- `req_data`  in  NUM_REQ×DATA_WIDTH  per-requester data (unpacked array).
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant; a transfer occurs on `req_valid[i] & req_ready[i]`.
- `clear_start`  in  1  single-cycle pulse requesting a full clear.
- `clear_busy`  out  1  high while the clear engine owns the port.
- `wea`  out  1  registered memory write enable.
- `addra`  out  AW  registered memory address.
- `dia`  out  DATA_WIDTH  registered memory data.

## Operation
- **States:** `CLEAR` and `IDLE`.
- **Reset:** asynchronous; the state machine goes to `CLEAR` with clear counter `cnt` = 0 and `rr_ptr` = 0.
- **CLEAR state:**
  - Each cycle registers `wea`=1, `addra`=`cnt`, `dia`=`CLEAR_VALUE`, then increments `cnt`.
  - When `cnt` == DEPTH-1, the counter returns to 0 and the state goes to `IDLE`.
  - `req_ready` is all-zero and `clear_start` is ignored.
- **IDLE state, with `clear_start`=1:**
  - No grant that cycle; `clear_start` has priority over all requesters.
  - Registers `wea`=0; the next state is `CLEAR` with `cnt`=0.
- **IDLE state, otherwise:**
  - Round-robin search starting at index `rr_ptr`, wrapping modulo `NUM_REQ`.
  - The first `i` with `req_valid[i]` gets `req_ready[i]`=1; all other ready bits are 0.
  - On a grant: register `wea`=1, `addra`=`req_addr[i]`, `dia`=`req_data[i]`, and set `rr_ptr` ← (i+1) mod `NUM_REQ`.
  - With no valid requester: register `wea`=0; `addra` and `dia` hold their values; `rr_ptr` holds.
- `req_ready` is combinational from `req_valid`, the state, `rr_ptr` and `clear_start`. Requesters must not make `req_valid` depend on `req_ready`.
- Requesters hold `req_valid`, `req_addr` and `req_data` stable until granted.
- `clear_busy` = (state == `CLEAR`).
- No read-port involvement; read/write collision semantics are those of the memory.

## Timing
- **Reset values:** `wea`=0, `addra`=0, `dia`=0, `req_ready`=0, `clear_busy`=1.
- **Write latency:** 1 cycle from handshake edge to `wea`/`addra`/`dia` valid. The memory commits on the following `clk` edge.
- **Throughput:** 1 write per cycle; with all requesters valid continuously, grants rotate 0,1,…,NUM_REQ-1,0,…
- **Clear duration:**
  - Exactly `DEPTH` consecutive `wea`=1 cycles covering addresses 0..DEPTH-1 in order.
  - Post-reset, the first clear write appears at the first `clk` edge after `reset` deasserts.
  - `clear_busy` falls at the edge that presents address DEPTH-1; a grant is possible in that same cycle.
- **`clear_start` from IDLE:** one idle cycle (`wea`=0), then `DEPTH` clear writes. `clear_busy` rises on the edge after the pulse.
- **Reset mid-clear or mid-transfer:** outputs drop to their reset values immediately and the clear restarts at address 0 after `reset` deasserts.
- **`DEPTH` not a power of two:** `cnt` never exceeds DEPTH-1.

## Test plan
- **Reset clear:** `DEPTH`=8, `CLEAR_VALUE`=8'h5A; deassert `reset` → 8 consecutive cycles of `wea`=1 with `addra` 0..7 and `dia`=5A; `clear_busy` falls with `addra`=7; the memory reads 5A everywhere.
- **Fairness:** `NUM_REQ`=3, all valid for 6 cycles → grant order 0,1,2,0,1,2 and six writes with matching `addra`/`dia` one cycle later.
- **Single requester:** only `req_valid[2]`, `addr`=5, `data`=8'hC3 → `req_ready[2]`=1 the same cycle; next cycle `wea`=1, `addra`=5, `dia`=C3; `rr_ptr`=0 afterwards.
- **clear_start contention:** `clear_start` pulse while `req_valid[0]`=1 → no ready that cycle; after 1+DEPTH cycles requester 0 is granted; a requester valid throughout sees `req_ready`=0 for the whole clear.
- **Reset during clear:** assert `reset` at `addra`=3 → outputs 0 immediately; after release the clear restarts from `addra`=0 with the full `DEPTH` length.
- **Non-power-of-two depth:** `DEPTH`=5 clear → `addra` goes 0..4 then IDLE; `addra` never reaches 5–7.
